// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if #(
    parameter int word_size = 16,
    parameter int addr_size = 16
);
    logic                 IMEM_REQ;
    logic [addr_size-1:0] IMEM_ADDR;
    logic                 IMEM_RDY;
    logic [word_size-1:0] IMEM_DATA;

    modport master (
        output IMEM_REQ,
        output IMEM_ADDR,
        input  IMEM_RDY,
        input  IMEM_DATA
    );

    modport slave (
        input  IMEM_REQ,
        input  IMEM_ADDR,
        output IMEM_RDY,
        output IMEM_DATA
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests one word at a time from instruction memory,
// holds it for decode, follows branch redirects and stops on the halt opcode.
module fetch_unit #(
    parameter int                   word_size = 16,
    parameter int                   addr_size = 16,
    parameter logic [addr_size-1:0] RESET_PC  = 16'h0000,
    parameter logic [3:0]           HALT_OP   = 4'hF
) (
    input  logic                 DCLK,
    input  logic                 RST_N,
    fetch_unit_if.master         imem,
    output logic [word_size-1:0] I_OUT,
    output logic                 I_VALID,
    input  logic                 I_ACCEPT,
    input  logic                 BR_TAKEN,
    input  logic [addr_size-1:0] BR_TARGET,
    output logic [addr_size-1:0] PC_OUT,
    output logic [15:0]          FETCH_CNT,
    output logic                 HALTED
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_HALT
    } state_t;

    state_t               state_q, state_d;
    logic [addr_size-1:0] pc_q, pc_d;
    logic                 req_q, req_d;
    logic [addr_size-1:0] addr_q, addr_d;
    logic [word_size-1:0] iout_q, iout_d;
    logic [addr_size-1:0] pcout_q, pcout_d;
    logic                 valid_q, valid_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 halted_q, halted_d;

    logic                 is_halt_op;

    assign is_halt_op = (imem.IMEM_DATA[word_size-1 -: 4] == HALT_OP);

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        addr_d   = addr_q;
        iout_d   = iout_q;
        pcout_d  = pcout_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (BR_TAKEN) pc_d = BR_TARGET;
            end

            // First FETCH cycle issues the request; later cycles wait for the strobe.
            // A redirect always wins and discards whatever response arrives with it.
            S_FETCH: begin
                if (BR_TAKEN) begin
                    pc_d    = BR_TARGET;
                    req_d   = 1'b0;
                    valid_d = 1'b0;
                end else if (!req_q) begin
                    req_d  = 1'b1;
                    addr_d = pc_q;
                end else if (imem.IMEM_RDY) begin
                    iout_d   = imem.IMEM_DATA;
                    pcout_d  = pc_q;
                    pc_d     = pc_q + addr_size'(1);
                    valid_d  = 1'b1;
                    req_d    = 1'b0;
                    halted_d = is_halt_op;
                    state_d  = is_halt_op ? S_HALT : S_HOLD;
                end
            end

            S_HOLD: begin
                if (BR_TAKEN) begin
                    pc_d    = BR_TARGET;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end else if (I_ACCEPT) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_FETCH;
                end
            end

            // Terminal until reset; the halt word itself can still be consumed once.
            S_HALT: begin
                if (valid_q && I_ACCEPT) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge DCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= '0;
            iout_q   <= '0;
            pcout_q  <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            iout_q   <= iout_d;
            pcout_q  <= pcout_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    assign imem.IMEM_REQ  = req_q;
    assign imem.IMEM_ADDR = addr_q;
    assign I_OUT          = iout_q;
    assign I_VALID        = valid_q;
    assign PC_OUT         = pcout_q;
    assign FETCH_CNT      = cnt_q;
    assign HALTED         = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios for reset, hold, redirect, wrap and halt,
// then randomized traffic scored against a transaction-level model of the fetch stream.
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [3:0]  HALT_OP  = 4'hF;
    localparam int          N_RAND   = 4000;

    logic        DCLK;
    logic        RST_N;
    logic [15:0] I_OUT;
    logic        I_VALID;
    logic        I_ACCEPT;
    logic        BR_TAKEN;
    logic [15:0] BR_TARGET;
    logic [15:0] PC_OUT;
    logic [15:0] FETCH_CNT;
    logic        HALTED;

    fetch_unit_if #(.word_size(16), .addr_size(16)) bus ();

    fetch_unit #(
        .word_size(16),
        .addr_size(16),
        .RESET_PC (RESET_PC),
        .HALT_OP  (HALT_OP)
    ) dut (
        .DCLK     (DCLK),
        .RST_N    (RST_N),
        .imem     (bus),
        .I_OUT    (I_OUT),
        .I_VALID  (I_VALID),
        .I_ACCEPT (I_ACCEPT),
        .BR_TAKEN (BR_TAKEN),
        .BR_TARGET(BR_TARGET),
        .PC_OUT   (PC_OUT),
        .FETCH_CNT(FETCH_CNT),
        .HALTED   (HALTED)
    );

    initial DCLK = 1'b0;
    always #5 DCLK = ~DCLK;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [65536];

    // Reference model state: the fetch stream as seen by decode.
    logic [15:0] exp_pc, exp_cnt, exp_iout, exp_pcout;
    logic        exp_valid, exp_halted;
    logic        p_req, p_rdy, p_acc, p_br;
    logic [15:0] p_addr, p_data, p_tgt;
    int          gap, halt_idle;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge DCLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_iout"},   I_OUT,         0);
        check({tag, "_valid"},  I_VALID,       0);
        check({tag, "_pcout"},  PC_OUT,        0);
        check({tag, "_req"},    bus.IMEM_REQ,  0);
        check({tag, "_addr"},   bus.IMEM_ADDR, 0);
        check({tag, "_cnt"},    FETCH_CNT,     0);
        check({tag, "_halted"}, HALTED,        0);
    endtask

    task automatic drive_idle();
        bus.IMEM_RDY  = 1'b0;
        bus.IMEM_DATA = 16'h0000;
        I_ACCEPT      = 1'b0;
        BR_TAKEN      = 1'b0;
        BR_TARGET     = 16'h0000;
    endtask

    // Called just after a clock edge: pulses reset and restarts the model.
    task automatic rnd_reset();
        drive_idle();
        RST_N = 1'b0;
        #2;
        check_reset_outputs("rnd_rst");
        RST_N      = 1'b1;
        exp_pc     = RESET_PC;
        exp_cnt    = 16'h0000;
        exp_valid  = 1'b0;
        exp_halted = 1'b0;
        p_req      = 1'b0;
        p_rdy      = 1'b0;
        p_acc      = 1'b0;
        p_br       = 1'b0;
        p_addr     = 16'h0000;
        p_data     = 16'h0000;
        p_tgt      = 16'h0000;
        gap        = 0;
        halt_idle  = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] w;
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if (w[15:12] == HALT_OP && $urandom_range(0, 3) != 0) w[15] = 1'b0;
            mem[i] = w;
        end

        // Reset and first fetch with a single-cycle memory response
        drive_idle();
        RST_N = 1'b0;
        #3;
        check_reset_outputs("por");
        @(negedge DCLK);
        RST_N = 1'b1;
        tick();
        check("idle_req", bus.IMEM_REQ, 0);
        tick();
        check("f0_req",  bus.IMEM_REQ,  1);
        check("f0_addr", bus.IMEM_ADDR, 16'h0000);
        bus.IMEM_RDY  = 1'b1;
        bus.IMEM_DATA = 16'h1234;
        tick();
        bus.IMEM_RDY = 1'b0;
        check("f0_valid", I_VALID,      1);
        check("f0_iout",  I_OUT,        16'h1234);
        check("f0_pcout", PC_OUT,       16'h0000);
        check("f0_req0",  bus.IMEM_REQ, 0);

        // Decode stalls for 5 cycles, then accepts
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_iout",  I_OUT,        16'h1234);
            check("hold_valid", I_VALID,      1);
            check("hold_req",   bus.IMEM_REQ, 0);
            check("hold_cnt",   FETCH_CNT,    0);
        end
        I_ACCEPT = 1'b1;
        tick();
        I_ACCEPT = 1'b0;
        check("acc_valid", I_VALID,      0);
        check("acc_cnt",   FETCH_CNT,    1);
        check("acc_req",   bus.IMEM_REQ, 0);
        tick();
        check("f1_req",  bus.IMEM_REQ,  1);
        check("f1_addr", bus.IMEM_ADDR, 16'h0001);

        // Redirect in the same cycle as the memory response
        bus.IMEM_RDY  = 1'b1;
        bus.IMEM_DATA = 16'h5555;
        BR_TAKEN      = 1'b1;
        BR_TARGET     = 16'h0040;
        tick();
        drive_idle();
        check("br_valid", I_VALID,      0);
        check("br_req",   bus.IMEM_REQ, 0);
        check("br_cnt",   FETCH_CNT,    1);
        tick();
        check("br_req1",  bus.IMEM_REQ,  1);
        check("br_addr",  bus.IMEM_ADDR, 16'h0040);

        // Fetch from 16'hFFFF, then the pc wraps to zero
        BR_TAKEN  = 1'b1;
        BR_TARGET = 16'hFFFF;
        tick();
        drive_idle();
        tick();
        check("wrap_addr_ff", bus.IMEM_ADDR, 16'hFFFF);
        check("wrap_req",     bus.IMEM_REQ,  1);
        bus.IMEM_RDY  = 1'b1;
        bus.IMEM_DATA = 16'h1111;
        tick();
        bus.IMEM_RDY = 1'b0;
        check("wrap_pcout", PC_OUT, 16'hFFFF);
        check("wrap_iout",  I_OUT,  16'h1111);
        I_ACCEPT = 1'b1;
        tick();
        I_ACCEPT = 1'b0;
        check("wrap_cnt", FETCH_CNT, 2);
        tick();
        check("wrap_addr0", bus.IMEM_ADDR, 16'h0000);
        check("wrap_req1",  bus.IMEM_REQ,  1);

        // Halt opcode; redirects and stray strobes are ignored until reset
        bus.IMEM_RDY  = 1'b1;
        bus.IMEM_DATA = 16'hF000;
        tick();
        check("halt_flag",  HALTED,       1);
        check("halt_valid", I_VALID,      1);
        check("halt_iout",  I_OUT,        16'hF000);
        check("halt_req",   bus.IMEM_REQ, 0);
        BR_TAKEN  = 1'b1;
        BR_TARGET = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_br_req",   bus.IMEM_REQ, 0);
            check("halt_br_valid", I_VALID,      1);
            check("halt_br_flag",  HALTED,       1);
        end
        drive_idle();
        I_ACCEPT = 1'b1;
        tick();
        I_ACCEPT = 1'b0;
        check("halt_acc_valid", I_VALID,   0);
        check("halt_acc_cnt",   FETCH_CNT, 3);
        bus.IMEM_RDY  = 1'b1;
        bus.IMEM_DATA = 16'h0ABC;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_stay_req",   bus.IMEM_REQ, 0);
            check("halt_stay_valid", I_VALID,      0);
        end
        drive_idle();
        RST_N = 1'b0;
        #2;
        check_reset_outputs("halt_rst");
        @(negedge DCLK);
        RST_N = 1'b1;
        tick();
        tick();
        check("restart_req",  bus.IMEM_REQ,  1);
        check("restart_addr", bus.IMEM_ADDR, RESET_PC);

        // Asynchronous reset with a response pending, no clock edge in between
        bus.IMEM_RDY  = 1'b1;
        bus.IMEM_DATA = 16'h2222;
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        drive_idle();
        @(negedge DCLK);
        RST_N = 1'b1;
        tick();
        check("post_rst_valid", I_VALID, 0);

        // Randomized traffic against the fetch-stream model
        tick();
        rnd_reset();
        for (int n = 0; n < N_RAND; n++) begin
            tick();
            if (p_br && !exp_halted) begin
                exp_pc    = p_tgt;
                exp_valid = 1'b0;
            end else if (exp_valid && p_acc) begin
                exp_cnt   = exp_cnt + 16'd1;
                exp_valid = 1'b0;
            end else if (p_req && p_rdy) begin
                exp_iout   = p_data;
                exp_pcout  = exp_pc;
                exp_valid  = 1'b1;
                if (p_data[15:12] == HALT_OP) exp_halted = 1'b1;
                exp_pc     = exp_pc + 16'd1;
            end

            check("rnd_valid",  I_VALID,   exp_valid);
            check("rnd_cnt",    FETCH_CNT, exp_cnt);
            check("rnd_halted", HALTED,    exp_halted);
            if (exp_valid) begin
                check("rnd_iout",  I_OUT,  exp_iout);
                check("rnd_pcout", PC_OUT, exp_pcout);
            end
            if (exp_valid || exp_halted) check("rnd_req_idle", bus.IMEM_REQ, 0);
            if (bus.IMEM_REQ) check("rnd_addr", bus.IMEM_ADDR, exp_pc);

            if (p_br) gap = 0;
            if (!exp_valid && !exp_halted && !bus.IMEM_REQ) gap++;
            else gap = 0;
            check("rnd_req_gap", (gap > 2), 0);

            if (exp_halted && !exp_valid) halt_idle++;
            if (halt_idle > 3 || $urandom_range(0, 299) == 0) begin
                rnd_reset();
            end else begin
                p_req  = bus.IMEM_REQ;
                p_addr = bus.IMEM_ADDR;
                if (p_req) begin
                    p_rdy  = ($urandom_range(0, 1) == 0);
                    p_data = mem[p_addr];
                end else begin
                    p_rdy  = ($urandom_range(0, 9) == 0);
                    p_data = 16'($urandom);
                end
                p_acc = ($urandom_range(0, 2) != 0);
                p_br  = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 1) == 0) p_tgt = 16'($urandom_range(0, 31));
                else                           p_tgt = 16'hFFF0 + 16'($urandom_range(0, 15));
                bus.IMEM_RDY  = p_rdy;
                bus.IMEM_DATA = p_data;
                I_ACCEPT      = p_acc;
                BR_TAKEN      = p_br;
                BR_TARGET     = p_tgt;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
